convertidor_bcd_binario: RTL and testbench

Multi-cycle packed-BCD to unsigned-binary converter. It is the inverse of the combinational binary-to-BCD path used by the display logic. It takes user or peripheral decimal entries, for example values keyed in on switches, and returns binary values for the RISC-V datapath. It uses the reverse double-dabble algorithm: shift right, then subtract 3 from every BCD digit that is ≥8. One iteration runs per clock, and valid/ready handshakes sit on both sides.

---
 rtl/convertidor_pkg.sv | 24 ++
 rtl/evalua_resta3.sv | 18 +
 rtl/convertidor_bcd_binario.sv | 154 +++++++++++++++
 tb/tb_convertidor_bcd_binario.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/convertidor_pkg.sv
// -----------------------------------------------------------------------------
// convertidor_pkg
// Shared definitions for the packed-BCD to binary converter.
//   estado_t        : control states of the converter FSM
//   BCD_NIBBLE      : width of one BCD digit field
//   LIMITE_8B       : largest value the 8-bit display path can show
//   digito_invalido : flags a nibble that is not a decimal digit
// -----------------------------------------------------------------------------
package convertidor_pkg;

   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      CONVIERTE = 2'd1,
      HECHO     = 2'd2
   } estado_t;

   localparam int BCD_NIBBLE = 4;
   localparam int LIMITE_8B  = 255;

   function automatic logic digito_invalido(input logic [BCD_NIBBLE-1:0] nibble);
      return (nibble > 4'd9);
   endfunction

endpackage

// File: rtl/evalua_resta3.sv
// -----------------------------------------------------------------------------
// evalua_resta3
// Per-digit correction step of the reverse double-dabble algorithm: after the
// right shift, a digit field of 8 or more has received the halved tens weight
// (10/2 = 5 instead of 8), so 3 is subtracted to restore a valid BCD digit.
//   valor     : shifted digit field
//   resultado : corrected digit field
// -----------------------------------------------------------------------------
module evalua_resta3
   import convertidor_pkg::*;
(
   input  logic [BCD_NIBBLE-1:0] valor,
   output logic [BCD_NIBBLE-1:0] resultado
);

   assign resultado = (valor >= 4'd8) ? (valor - 4'd3) : valor;

endmodule

// File: rtl/convertidor_bcd_binario.sv
// -----------------------------------------------------------------------------
// convertidor_bcd_binario
// Multi-cycle packed-BCD to unsigned binary converter (reverse double dabble),
// one shift/correct iteration per clock, valid/ready on both sides.
//   clk            : system clock, rising edge
//   rst_n          : synchronous active-low reset
//   bcd_in         : packed BCD input, digit 0 in [3:0]
//   valido_entrada : bcd_in is valid
//   listo_entrada  : converter can accept an input (only in REPOSO)
//   binario        : converted value
//   error_bcd      : some input nibble was > 9 (binario forced to 0)
//   valido_salida  : binario / error_bcd are valid
//   listo_salida   : consumer accepts the result
//   desborde       : (CONVERTIDOR_SATURA_8B_EN only) result saturated to 255
// Build option: define CONVERTIDOR_SATURA_8B_EN to clamp results to 8 bits.
// -----------------------------------------------------------------------------
module convertidor_bcd_binario
   import convertidor_pkg::*;
#(
   parameter int DIGITOS = 3,
   parameter int ANCHO   = 10
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [BCD_NIBBLE*DIGITOS-1:0] bcd_in,
   input  logic                          valido_entrada,
   output logic                          listo_entrada,
   output logic [ANCHO-1:0]              binario,
   output logic                          error_bcd,
   output logic                          valido_salida,
`ifdef CONVERTIDOR_SATURA_8B_EN
   output logic                          desborde,
`endif
   input  logic                          listo_salida
);

   localparam int ANCHO_BCD = BCD_NIBBLE * DIGITOS;
   localparam int ANCHO_REG = ANCHO_BCD + ANCHO;
   localparam int ANCHO_CNT = ($clog2(ANCHO) > 0) ? $clog2(ANCHO) : 1;
   localparam longint MAXIMO_BCD = (longint'(10) ** DIGITOS) - 1;

   // The binary field must hold the largest decimal input without wrapping.
   generate
      if ((longint'(1) << ANCHO) <= MAXIMO_BCD) begin : g_ancho_insuficiente
         $error("ANCHO too small for DIGITOS BCD digits");
      end
   endgenerate

   estado_t                estado, estado_sig;
   logic [ANCHO_REG-1:0]   registro, desplazado, corregido;
   logic [ANCHO_CNT-1:0]   contador;
   logic                   hay_error;
   logic                   ultima;
   logic [ANCHO-1:0]       resultado;

   // Shift the whole register right; the binary field just passes through,
   // every BCD digit field gets its -3 correction.
   assign desplazado = registro >> 1;
   assign corregido[ANCHO-1:0] = desplazado[ANCHO-1:0];

   genvar d;
   generate
      for (d = 0; d < DIGITOS; d++) begin : g_digito
         evalua_resta3 u_resta3 (
            .valor     (desplazado[ANCHO + d*BCD_NIBBLE +: BCD_NIBBLE]),
            .resultado (corregido [ANCHO + d*BCD_NIBBLE +: BCD_NIBBLE])
         );
      end
   endgenerate

   always_comb begin
      hay_error = 1'b0;
      for (int i = 0; i < DIGITOS; i++) begin
         hay_error = hay_error | digito_invalido(bcd_in[i*BCD_NIBBLE +: BCD_NIBBLE]);
      end
   end

   assign ultima        = (contador == ANCHO_CNT'(ANCHO - 1));
   assign listo_entrada = (estado == REPOSO);

`ifdef CONVERTIDOR_SATURA_8B_EN
   logic satura;
   assign satura    = (corregido[ANCHO-1:0] > ANCHO'(LIMITE_8B));
   assign resultado = satura ? ANCHO'(LIMITE_8B) : corregido[ANCHO-1:0];
`else
   assign resultado = corregido[ANCHO-1:0];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado <= REPOSO;
      end else begin
         estado <= estado_sig;
      end
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         REPOSO:    if (valido_entrada) estado_sig = hay_error ? HECHO : CONVIERTE;
         CONVIERTE: if (ultima)         estado_sig = HECHO;
         HECHO:     if (listo_salida)   estado_sig = REPOSO;
         default:                       estado_sig = REPOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         registro      <= '0;
         contador      <= '0;
         binario       <= '0;
         error_bcd     <= 1'b0;
         valido_salida <= 1'b0;
`ifdef CONVERTIDOR_SATURA_8B_EN
         desborde      <= 1'b0;
`endif
      end else begin
         case (estado)
            REPOSO: begin
               if (valido_entrada) begin
                  registro  <= {bcd_in, {ANCHO{1'b0}}};
                  contador  <= '0;
                  error_bcd <= hay_error;
`ifdef CONVERTIDOR_SATURA_8B_EN
                  desborde  <= 1'b0;
`endif
                  // A malformed entry skips the iterations and reports at once.
                  if (hay_error) begin
                     binario       <= '0;
                     valido_salida <= 1'b1;
                  end
               end
            end
            CONVIERTE: begin
               registro <= corregido;
               contador <= contador + ANCHO_CNT'(1);
               if (ultima) begin
                  binario       <= resultado;
                  valido_salida <= 1'b1;
`ifdef CONVERTIDOR_SATURA_8B_EN
                  desborde      <= satura;
`endif
               end
            end
            HECHO: begin
               if (listo_salida) valido_salida <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_convertidor_bcd_binario.sv
// -----------------------------------------------------------------------------
// tb_convertidor_bcd_binario
// Directed self-checking bench for convertidor_bcd_binario (DIGITOS=3,
// ANCHO=10). Inputs are driven and outputs sampled on the falling edge.
// Build option: CONVERTIDOR_SATURA_8B_EN adds the saturation cases.
// -----------------------------------------------------------------------------
module tb_convertidor_bcd_binario;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] bcd_in;
   logic        valido_entrada;
   logic        listo_entrada;
   logic [9:0]  binario;
   logic        error_bcd;
   logic        valido_salida;
   logic        listo_salida;
`ifdef CONVERTIDOR_SATURA_8B_EN
   logic        desborde;
`endif

   int total    = 0;
   int aprobados = 0;

   always #5 clk = ~clk;

   convertidor_bcd_binario #(.DIGITOS(3), .ANCHO(10)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bcd_in         (bcd_in),
      .valido_entrada (valido_entrada),
      .listo_entrada  (listo_entrada),
      .binario        (binario),
      .error_bcd      (error_bcd),
      .valido_salida  (valido_salida),
`ifdef CONVERTIDOR_SATURA_8B_EN
      .desborde       (desborde),
`endif
      .listo_salida   (listo_salida)
   );

   task automatic comprueba(input string etiqueta, input logic [31:0] obtenido,
                            input logic [31:0] esperado);
      total++;
      if (obtenido === esperado) aprobados++;
      else $display("FAIL %s: got %0d expected %0d", etiqueta, obtenido, esperado);
   endtask

   // Value the converter reports for a decimal entry in this build.
   function automatic int esperado_bin(input int v);
`ifdef CONVERTIDOR_SATURA_8B_EN
      return (v > 255) ? 255 : v;
`else
      return v;
`endif
   endfunction

   // Wait for valido_salida after the accept edge; returns edges elapsed.
   task automatic espera_resultado(output int lat);
      lat = 0;
      while (!valido_salida && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Full transaction: accept, latency, result, retirement.
   task automatic convierte(input string etiqueta, input logic [11:0] bcd,
                            input int exp_bin, input logic exp_err, input int exp_lat);
      int lat;
      @(negedge clk);
      comprueba({etiqueta, " listo_entrada before"}, 32'(listo_entrada), 32'd1);
      bcd_in = bcd;
      valido_entrada = 1'b1;
      @(posedge clk);                 // accept edge
      @(negedge clk);
      valido_entrada = 1'b0;
      bcd_in = 12'h000;
      comprueba({etiqueta, " listo_entrada busy"}, 32'(listo_entrada), 32'd0);
      espera_resultado(lat);
      comprueba({etiqueta, " latency"}, 32'(lat), 32'(exp_lat));
      comprueba({etiqueta, " binario"}, 32'(binario), 32'(exp_bin));
      comprueba({etiqueta, " error_bcd"}, 32'(error_bcd), 32'(exp_err));
`ifdef CONVERTIDOR_SATURA_8B_EN
      comprueba({etiqueta, " desborde"}, 32'(desborde), 32'(exp_bin == 255 && !exp_err
                && bcd != 12'h255));
`endif
      listo_salida = 1'b1;
      @(negedge clk);
      listo_salida = 1'b0;
      comprueba({etiqueta, " retired"}, 32'(valido_salida), 32'd0);
      comprueba({etiqueta, " back to idle"}, 32'(listo_entrada), 32'd1);
   endtask

   initial begin
      int lat;
      logic visto;
      rst_n = 1'b0;
      bcd_in = 12'h000;
      valido_entrada = 1'b0;
      listo_salida = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      comprueba("reset listo_entrada", 32'(listo_entrada), 32'd1);
      comprueba("reset valido_salida", 32'(valido_salida), 32'd0);
      comprueba("reset binario", 32'(binario), 32'd0);
      comprueba("reset error_bcd", 32'(error_bcd), 32'd0);
      rst_n = 1'b1;

      convierte("bcd255", 12'h255, esperado_bin(255), 1'b0, 10);
      convierte("bcd999", 12'h999, esperado_bin(999), 1'b0, 10);
      convierte("bcd000", 12'h000, 0, 1'b0, 10);
      convierte("bcd1A3", 12'h1A3, 0, 1'b1, 0);
      convierte("bcd407", 12'h407, esperado_bin(407), 1'b0, 10);
      convierte("bcd0F0", 12'h0F0, 0, 1'b1, 0);
      convierte("bcd009", 12'h009, 9, 1'b0, 10);
`ifdef CONVERTIDOR_SATURA_8B_EN
      convierte("sat300", 12'h300, 255, 1'b0, 10);
      convierte("sat200", 12'h200, 200, 1'b0, 10);
`endif

      // Backpressure: result held, new requests ignored while in HECHO.
      @(negedge clk);
      bcd_in = 12'h042;
      valido_entrada = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valido_entrada = 1'b0;
      espera_resultado(lat);
      comprueba("bp latency", 32'(lat), 32'd10);
      bcd_in = 12'h777;
      valido_entrada = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         comprueba("bp valido_salida held", 32'(valido_salida), 32'd1);
         comprueba("bp binario held", 32'(binario), 32'd42);
         comprueba("bp error_bcd held", 32'(error_bcd), 32'd0);
         comprueba("bp listo_entrada low", 32'(listo_entrada), 32'd0);
      end
      listo_salida = 1'b1;
      @(negedge clk);                 // retirement edge, request still ignored
      listo_salida = 1'b0;
      comprueba("bp retired", 32'(valido_salida), 32'd0);
      comprueba("bp idle", 32'(listo_entrada), 32'd1);
      comprueba("bp binario kept", 32'(binario), 32'd42);
      @(posedge clk);                 // pending request accepted now
      @(negedge clk);
      valido_entrada = 1'b0;
      comprueba("bp late accept", 32'(listo_entrada), 32'd0);
      espera_resultado(lat);
      comprueba("bp777 latency", 32'(lat), 32'd10);
      comprueba("bp777 binario", 32'(binario), 32'(esperado_bin(777)));
      listo_salida = 1'b1;
      @(negedge clk);
      listo_salida = 1'b0;

      // Reset in the middle of a conversion.
      bcd_in = 12'h123;
      valido_entrada = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valido_entrada = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      comprueba("midrst listo_entrada", 32'(listo_entrada), 32'd1);
      comprueba("midrst valido_salida", 32'(valido_salida), 32'd0);
      comprueba("midrst binario", 32'(binario), 32'd0);
      visto = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (valido_salida) visto = 1'b1;
      end
      comprueba("midrst no stale result", 32'(visto), 32'd0);

      convierte("post_reset bcd068", 12'h068, 68, 1'b0, 10);

      $display("%0d/%0d checks passed", aprobados, total);
      $finish;
   end

endmodule
